// File: rtl/apb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// apb_mem_arbiter
//   Shares a single APB memory slave between the CPU instruction-fetch port
//   and the load/store data port. One APB transfer is in flight at a time
//   (SETUP then ACCESS). A slave that holds PREADY low is aborted after a
//   bounded number of ACCESS cycles. Each port sees its completion as a
//   one-cycle READY pulse.
//
// Build option
//   ARB_RR_EN  defined   : a tie goes to the port that was not granted last
//                          (round-robin). last_grant resets to INST, so DATA
//                          wins the first tie after reset.
//              undefined : fixed priority, DATA beats INST on every tie.
//
// Parameters
//   AW       address width
//   DW       data width
//   TIMEOUT  ACCESS cycles with PREADY=0 before abort (0 = never abort).
//            The wait counter is 8 bits wide.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous reset, active low
//   hold_ni        0 = no new grant; a transfer already in flight completes
//   inst_req_i     instruction read request, held until inst_ready_o
//   inst_addr_i    instruction address
//   inst_rdata_o   fetched word, held until the next instruction completion
//   inst_ready_o   one-cycle instruction completion pulse
//   data_req_i     data request, held until data_ready_o
//   data_write_i   1 = write, 0 = read
//   data_addr_i    data address
//   data_wdata_i   write data
//   data_rdata_o   read word, held until the next data completion
//   data_ready_o   one-cycle data completion pulse
//   err_o          high with the READY pulse when the transfer timed out
//   psel_o, penable_o, pwrite_o, paddr_o, pwdata_o   APB master outputs
//   prdata_i, pready_i                               APB slave responses
// ----------------------------------------------------------------------------
module apb_mem_arbiter #(
  parameter int AW      = 11,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          hold_ni,

  input  logic          inst_req_i,
  input  logic [AW-1:0] inst_addr_i,
  output logic [DW-1:0] inst_rdata_o,
  output logic          inst_ready_o,

  input  logic          data_req_i,
  input  logic          data_write_i,
  input  logic [AW-1:0] data_addr_i,
  input  logic [DW-1:0] data_wdata_i,
  output logic [DW-1:0] data_rdata_o,
  output logic          data_ready_o,

  output logic          err_o,

  output logic          psel_o,
  output logic          penable_o,
  output logic          pwrite_o,
  output logic [AW-1:0] paddr_o,
  output logic [DW-1:0] pwdata_o,
  input  logic [DW-1:0] prdata_i,
  input  logic          pready_i
);

  // state  | meaning
  // -------+------------------------------------------------------------
  // IDLE   | bus quiet; grant a pending request when hold_ni is high
  // SETUP  | PSEL=1, PENABLE=0 with latched address/control
  // ACCESS | PSEL=1, PENABLE=1; wait for PREADY or the timeout
  // DONE   | bus quiet; owner READY (and ERR if aborted) for one cycle
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic       TO_EN  = (TIMEOUT != 0);
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_e          state_q;
  logic            owner_data_q;   // 1 = current transfer belongs to DATA
  logic [7:0]      cnt_q;
  logic [7:0]      cnt_d;
  logic            timeout_hit;
  logic            grant_data_d;
  logic            any_req;

  logic            psel_q;
  logic            penable_q;
  logic            pwrite_q;
  logic [AW-1:0]   paddr_q;
  logic [DW-1:0]   pwdata_q;
  logic [DW-1:0]   inst_rdata_q;
  logic [DW-1:0]   data_rdata_q;
  logic            inst_ready_q;
  logic            data_ready_q;
  logic            err_q;

`ifdef ARB_RR_EN
  logic            last_grant_data_q;  // 0 = INST was granted last
`endif

  assign any_req = inst_req_i | data_req_i;
  assign cnt_d   = cnt_q + 8'd1;

  // Abort on the ACCESS cycle whose wait brings the count up to TIMEOUT.
  assign timeout_hit = TO_EN && (cnt_d == TO_LIM);

  always_comb begin
    grant_data_d = 1'b0;
`ifdef ARB_RR_EN
    // On a tie, DATA wins only if INST was the previous owner.
    grant_data_d = data_req_i & (~inst_req_i | ~last_grant_data_q);
`else
    grant_data_d = data_req_i;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= S_IDLE;
      owner_data_q      <= 1'b0;
      cnt_q             <= 8'd0;
      psel_q            <= 1'b0;
      penable_q         <= 1'b0;
      pwrite_q          <= 1'b0;
      paddr_q           <= '0;
      pwdata_q          <= '0;
      inst_rdata_q      <= '0;
      data_rdata_q      <= '0;
      inst_ready_q      <= 1'b0;
      data_ready_q      <= 1'b0;
      err_q             <= 1'b0;
`ifdef ARB_RR_EN
      last_grant_data_q <= 1'b0;
`endif
    end else begin
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      err_q        <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (hold_ni && any_req) begin
            owner_data_q <= grant_data_d;
            psel_q       <= 1'b1;
            cnt_q        <= 8'd0;
            if (grant_data_d) begin
              paddr_q  <= data_addr_i;
              pwrite_q <= data_write_i;
              pwdata_q <= data_wdata_i;
            end else begin
              paddr_q  <= inst_addr_i;
              pwrite_q <= 1'b0;
              pwdata_q <= '0;
            end
`ifdef ARB_RR_EN
            last_grant_data_q <= grant_data_d;
`endif
            state_q <= S_SETUP;
          end
        end

        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end

        S_ACCESS: begin
          if (pready_i || timeout_hit) begin
            if (pready_i) begin
              if (!pwrite_q) begin
                if (owner_data_q) data_rdata_q <= prdata_i;
                else              inst_rdata_q <= prdata_i;
              end
            end else begin
              // Aborted transfer returns zero to its owner, even for writes.
              err_q <= 1'b1;
              if (owner_data_q) data_rdata_q <= '0;
              else              inst_rdata_q <= '0;
            end
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            inst_ready_q <= ~owner_data_q;
            data_ready_q <= owner_data_q;
            state_q      <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign psel_o       = psel_q;
  assign penable_o    = penable_q;
  assign pwrite_o     = pwrite_q;
  assign paddr_o      = paddr_q;
  assign pwdata_o     = pwdata_q;
  assign inst_rdata_o = inst_rdata_q;
  assign data_rdata_o = data_rdata_q;
  assign inst_ready_o = inst_ready_q;
  assign data_ready_o = data_ready_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_apb_mem_arbiter.sv
module tb_apb_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hold_n = 1'b1;
  logic          inst_req = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic          data_req = 1'b0;
  logic          data_write = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;

  logic [DW-1:0] inst_rdata_o, data_rdata_o, pwdata_o;
  logic [AW-1:0] paddr_o;
  logic          inst_ready_o, data_ready_o, err_o;
  logic          psel_o, penable_o, pwrite_o;

  int vectors = 0;
  int fails   = 0;

  apb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .hold_ni      (hold_n),
    .inst_req_i   (inst_req),
    .inst_addr_i  (inst_addr),
    .inst_rdata_o (inst_rdata_o),
    .inst_ready_o (inst_ready_o),
    .data_req_i   (data_req),
    .data_write_i (data_write),
    .data_addr_i  (data_addr),
    .data_wdata_i (data_wdata),
    .data_rdata_o (data_rdata_o),
    .data_ready_o (data_ready_o),
    .err_o        (err_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .prdata_i     (prdata),
    .pready_i     (pready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- APB slave: PREADY after slave_waits ACCESS cycles ----------------
  int acc_cnt     = 0;
  int slave_waits = 0;
  bit slave_stuck = 1'b0;

  always @(negedge clk) begin
    if (psel_o && penable_o) begin
      pready = !slave_stuck && (acc_cnt >= slave_waits);
      acc_cnt++;
    end else begin
      pready  = 1'b0;
      acc_cnt = 0;
    end
  end

  // ---------------- Transfer-level reference model ----------------
  // m_phase counts where the current transfer is: 0 none, 1 address phase,
  // 2 data phase (waiting), 3 completion cycle.
  int            m_phase;
  bit            m_data;
  bit            m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_waits;
  bit            m_err;
  logic [DW-1:0] m_irdata, m_drdata;
  bit            m_last_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_data = 0; m_write = 0; m_addr = '0; m_wdata = '0;
      m_waits = 0; m_err = 0; m_irdata = '0; m_drdata = '0; m_last_data = 0;
    end else if (m_phase == 0) begin
      if (hold_n && (inst_req || data_req)) begin
`ifdef ARB_RR_EN
        m_data = data_req && (!inst_req || !m_last_data);
`else
        m_data = data_req;
`endif
        m_last_data = m_data;
        m_write = m_data && data_write;
        m_addr  = m_data ? data_addr : inst_addr;
        m_wdata = m_data ? data_wdata : '0;
        m_waits = 0;
        m_err   = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2) begin
      if (pready) begin
        if (!m_write) begin
          if (m_data) m_drdata = prdata; else m_irdata = prdata;
        end
        m_phase = 3;
      end else begin
        m_waits++;
        if (TO != 0 && m_waits == TO) begin
          m_err = 1;
          if (m_data) m_drdata = '0; else m_irdata = '0;
          m_phase = 3;
        end
      end
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    bit on_bus;
    on_bus = (m_phase == 1) || (m_phase == 2);
    check("psel",       psel_o,       on_bus);
    check("penable",    penable_o,    m_phase == 2);
    check("paddr",      paddr_o,      on_bus ? m_addr : '0);
    check("pwrite",     pwrite_o,     on_bus && m_write);
    check("pwdata",     pwdata_o,     on_bus ? m_wdata : '0);
    check("inst_ready", inst_ready_o, (m_phase == 3) && !m_data);
    check("data_ready", data_ready_o, (m_phase == 3) && m_data);
    check("err",        err_o,        (m_phase == 3) && m_err);
    check("inst_rdata", inst_rdata_o, m_irdata);
    check("data_rdata", data_rdata_o, m_drdata);
  end

  // ---------------- Requester driver ----------------
  // Runs until both REQs are dropped; each REQ drops at the edge ending its READY.
  // Owner codes: 1 = INST, 2 = DATA.
  task automatic run(input int budget, output int first, output int second,
                     output int acc, output bit last_err);
    int  n;
    bit  di, dd;
    n = 0; first = 0; second = 0; acc = 0; last_err = 0;
    while ((inst_req || data_req) && n < budget) begin
      @(negedge clk);
      n++;
      if (penable_o) acc++;
      di = inst_ready_o;
      dd = data_ready_o;
      if (di || dd) begin
        last_err = err_o;
        if (first == 0) first = dd ? 2 : 1;
        else            second = dd ? 2 : 1;
      end
      @(posedge clk); #1;
      if (di) inst_req = 1'b0;
      if (dd) data_req = 1'b0;
    end
    if (inst_req || data_req) begin
      check("request_completion_timeout", 32'(n), 32'(budget + 1));
      inst_req = 1'b0;
      data_req = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int  f, s, a, k;
    bit  e;

    repeat (2) @(negedge clk);
    check("rst_psel",       psel_o, 0);
    check("rst_inst_rdata", inst_rdata_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: zero-wait instruction fetch, hand-timed cycle by cycle
    slave_waits = 0; prdata = 16'hA5A5;
    inst_addr = 11'h005; inst_req = 1'b1;
    @(negedge clk); check("t1_c0_psel", psel_o, 0);
    @(negedge clk); check("t1_c1_psel", psel_o, 1);
                    check("t1_c1_penable", penable_o, 0);
                    check("t1_c1_paddr", paddr_o, 11'h005);
    @(negedge clk); check("t1_c2_penable", penable_o, 1);
    @(negedge clk); check("t1_c3_ready", inst_ready_o, 1);
                    check("t1_c3_rdata", inst_rdata_o, 16'hA5A5);
                    check("t1_c3_err", err_o, 0);
    @(posedge clk); #1 inst_req = 1'b0;

    // 2: data write with three wait states, then a read with one
    slave_waits = 3;
    data_addr = 11'h010; data_wdata = 16'h1234; data_write = 1'b1; data_req = 1'b1;
    run(20, f, s, a, e);
    check("t2_owner", f, 2);
    check("t2_access_cycles", a, 4);
    check("t2_err", e, 0);
    data_write = 1'b0;
    slave_waits = 1; prdata = 16'h5A5A; data_addr = 11'h020; data_req = 1'b1;
    run(20, f, s, a, e);
    check("t2_read_rdata", data_rdata_o, 16'h5A5A);
    check("t2_read_access_cycles", a, 2);

    // 3: ties; first after reset goes to DATA in both builds
    pulse_reset();
    slave_waits = 0; prdata = 16'h0F0F;
    inst_addr = 11'h030; data_addr = 11'h040;
    inst_req = 1'b1; data_req = 1'b1;
    run(30, f, s, a, e);
    check("t3_tie1_first", f, 2);
    check("t3_tie1_second", s, 1);
    data_req = 1'b1;
    run(20, f, s, a, e);
    inst_req = 1'b1; data_req = 1'b1;
    run(30, f, s, a, e);
`ifdef ARB_RR_EN
    check("t3_tie2_first", f, 1);
`else
    check("t3_tie2_first", f, 2);
`endif

    // 4: stuck slave aborts after TO ACCESS cycles
    slave_stuck = 1'b1; prdata = 16'hFFFF;
    data_addr = 11'h050; data_req = 1'b1;
    run(20, f, s, a, e);
    check("t4_access_cycles", a, TO);
    check("t4_err", e, 1);
    check("t4_rdata", data_rdata_o, 0);
    check("t4_psel_after", psel_o, 0);
    slave_stuck = 1'b0;

    // 5: hold blocks grants but not an in-flight transfer
    hold_n = 1'b0; inst_addr = 11'h060; inst_req = 1'b1; prdata = 16'h1111;
    repeat (5) begin
      @(negedge clk); check("t5_hold_psel", psel_o, 0);
    end
    @(posedge clk); #1 hold_n = 1'b1;
    slave_waits = 2;
    k = 0;
    while (!penable_o && k < 10) begin @(negedge clk); k++; end
    check("t5_reached_access", penable_o, 1);
    hold_n = 1'b0;
    run(20, f, s, a, e);
    check("t5_owner", f, 1);
    check("t5_rdata", inst_rdata_o, 16'h1111);
    @(posedge clk); #1 hold_n = 1'b1;

    // 6: reset in ACCESS drops the bus at once; held REQ restarts afterwards
    slave_waits = 3; prdata = 16'h2222; inst_addr = 11'h070; inst_req = 1'b1;
    k = 0;
    while (!penable_o && k < 10) begin @(negedge clk); k++; end
    check("t6_reached_access", penable_o, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_psel", psel_o, 0);
    check("t6_rst_penable", penable_o, 0);
    check("t6_rst_ready", inst_ready_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    slave_waits = 1;
    run(20, f, s, a, e);
    check("t6_restart_owner", f, 1);
    check("t6_restart_rdata", inst_rdata_o, 16'h2222);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
